rv32_ahb_lite_master_pipe: RTL

Parametrised, fully pipelined AHB-Lite master for the RV32IM cores. It accepts independent instruction-fetch and load/store request channels through valid/ready handshakes and arbitrates them onto a single AHB-Lite port with proper address/data phase overlap. It honours HREADY wait states and the two-cycle HRESP error response, and performs byte-lane write replication and read extraction with sign or zero extension. It sits between the core's fetch/LSU stages and the SoC interconnect.

---
 rtl/rv32_ahb_lite_master_pipe.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32_ahb_lite_master_pipe.sv
// rtl/rv32_ahb_lite_master_pipe.sv - fetch and load/store request channels arbitrated onto one pipelined AHB-Lite master port
module rv32_ahb_lite_master_pipe #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_ARB = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_rdata,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic              ls_req_write,
  input  logic [1:0]        ls_req_size,
  input  logic              ls_req_unsigned,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_rdata,
  output logic              ls_rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int         LANE_W        = (DATA_W == 64) ? 3 : 2;
  localparam logic [1:0] FULL_SIZE     = (DATA_W == 64) ? 2'd3 : 2'd2;
  localparam logic       CH_IF         = 1'b0;
  localparam logic       CH_LS         = 1'b1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  function automatic logic ls_misaligned(input logic [1:0] size, input logic [2:0] low);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return low[0];
      2'd2:    return |low[1:0];
      default: return (DATA_W == 32) || (|low);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size, input logic [DATA_W-1:0] d);
    case (size)
      2'd0:    return {(DATA_W/8){d[7:0]}};
      2'd1:    return {(DATA_W/16){d[15:0]}};
      2'd2:    return {(DATA_W/32){d[31:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [1:0] size, input logic uns,
                                                input logic [LANE_W-1:0] off,
                                                input logic [DATA_W-1:0] rd);
    logic [DATA_W-1:0] s;
    logic              sb;
    int                w;
    s = rd >> {off, 3'b000};
    case (size)
      2'd0:    begin w = 8;      sb = s[7];        end
      2'd1:    begin w = 16;     sb = s[15];       end
      2'd2:    begin w = 32;     sb = s[31];       end
      default: begin w = DATA_W; sb = s[DATA_W-1]; end
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= w) s[i] = sb & ~uns;
    end
    return s;
  endfunction

  logic              ap_valid_q, ap_valid_d;
  logic              ap_ch_q, ap_ch_d;
  logic              ap_write_q, ap_write_d;
  logic [1:0]        ap_size_q, ap_size_d;
  logic              ap_unsigned_q, ap_unsigned_d;
  logic [3:0]        ap_prot_q, ap_prot_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
  logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;

  logic              dp_valid_q, dp_valid_d;
  logic              dp_ch_q, dp_ch_d;
  logic              dp_write_q, dp_write_d;
  logic [1:0]        dp_size_q, dp_size_d;
  logic              dp_unsigned_q, dp_unsigned_d;
  logic [LANE_W-1:0] dp_off_q, dp_off_d;
  logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;

  logic              rr_last_q, rr_last_d;
  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic              if_rsp_err_q, if_rsp_err_d;
  logic [DATA_W-1:0] if_rsp_rdata_q, if_rsp_rdata_d;
  logic              ls_rsp_valid_q, ls_rsp_valid_d;
  logic              ls_rsp_err_q, ls_rsp_err_d;
  logic [DATA_W-1:0] ls_rsp_rdata_q, ls_rsp_rdata_d;

  logic              ap_adv, slot_free, if_busy, ls_busy, if_can, ls_can, ls_pri;
  logic              if_hs, ls_hs, if_mis, ls_mis;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] rsp_data;

  // The address phase only advances on a clean HREADY; during either error cycle it is held.
  assign ap_adv    = ap_valid_q && HREADY && !HRESP;
  assign slot_free = !ap_valid_q || ap_adv;
  assign if_busy   = (ap_valid_q && ap_ch_q == CH_IF) || (dp_valid_q && dp_ch_q == CH_IF) || if_rsp_valid_q;
  assign ls_busy   = (ap_valid_q && ap_ch_q == CH_LS) || (dp_valid_q && dp_ch_q == CH_LS) || ls_rsp_valid_q;
  assign if_can    = !if_busy && slot_free;
  assign ls_can    = !ls_busy && slot_free;
  assign ls_pri    = (RR_ARB == 0) || (rr_last_q == CH_IF);

  assign if_req_ready = if_can && !(ls_req_valid && ls_can && ls_pri);
  assign ls_req_ready = ls_can && !(if_req_valid && if_can && !ls_pri);
  assign if_hs        = if_req_valid && if_req_ready;
  assign ls_hs        = ls_req_valid && ls_req_ready;
  assign if_mis       = |if_req_addr[1:0];
  assign ls_mis       = ls_misaligned(ls_req_size, ls_req_addr[2:0]);

  always_comb begin
    fetch_addr               = if_req_addr;
    fetch_addr[LANE_W-1:0]   = '0;
  end

  always_comb begin
    ap_valid_d     = ap_valid_q;
    ap_ch_d        = ap_ch_q;
    ap_write_d     = ap_write_q;
    ap_size_d      = ap_size_q;
    ap_unsigned_d  = ap_unsigned_q;
    ap_prot_d      = ap_prot_q;
    ap_addr_d      = ap_addr_q;
    ap_wdata_d     = ap_wdata_q;
    dp_valid_d     = dp_valid_q;
    dp_ch_d        = dp_ch_q;
    dp_write_d     = dp_write_q;
    dp_size_d      = dp_size_q;
    dp_unsigned_d  = dp_unsigned_q;
    dp_off_d       = dp_off_q;
    dp_wdata_d     = dp_wdata_q;
    rr_last_d      = rr_last_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_err_d   = 1'b0;
    if_rsp_rdata_d = '0;
    ls_rsp_valid_d = 1'b0;
    ls_rsp_err_d   = 1'b0;
    ls_rsp_rdata_d = '0;
    rsp_data       = '0;

    if (dp_valid_q && HREADY) begin
      if (!HRESP && !dp_write_q) begin
        rsp_data = (dp_ch_q == CH_IF) ? HRDATA
                                      : extract(dp_size_q, dp_unsigned_q, dp_off_q, HRDATA);
      end
      if (dp_ch_q == CH_IF) begin
        if_rsp_valid_d = 1'b1;
        if_rsp_err_d   = HRESP;
        if_rsp_rdata_d = rsp_data;
      end else begin
        ls_rsp_valid_d = 1'b1;
        ls_rsp_err_d   = HRESP;
        ls_rsp_rdata_d = rsp_data;
      end
    end

    if (HREADY) begin
      dp_valid_d = ap_adv;
      if (ap_adv) begin
        dp_ch_d       = ap_ch_q;
        dp_write_d    = ap_write_q;
        dp_size_d     = ap_size_q;
        dp_unsigned_d = ap_unsigned_q;
        dp_off_d      = ap_addr_q[LANE_W-1:0];
        dp_wdata_d    = ap_wdata_q;
      end
    end

    if (ap_adv) ap_valid_d = 1'b0;

    // Misaligned requests bypass the bus and answer straight from the response register.
    if (if_hs || ls_hs) begin
      rr_last_d = ls_hs ? CH_LS : CH_IF;
      if (ls_hs ? ls_mis : if_mis) begin
        if (ls_hs) begin
          ls_rsp_valid_d = 1'b1;
          ls_rsp_err_d   = 1'b1;
        end else begin
          if_rsp_valid_d = 1'b1;
          if_rsp_err_d   = 1'b1;
        end
      end else begin
        ap_valid_d = 1'b1;
        ap_ch_d    = ls_hs;
        if (ls_hs) begin
          ap_addr_d     = ls_req_addr;
          ap_write_d    = ls_req_write;
          ap_size_d     = ls_req_size;
          ap_unsigned_d = ls_req_unsigned;
          ap_prot_d     = 4'b0011;
          ap_wdata_d    = replicate(ls_req_size, ls_req_wdata);
        end else begin
          ap_addr_d     = fetch_addr;
          ap_write_d    = 1'b0;
          ap_size_d     = FULL_SIZE;
          ap_unsigned_d = 1'b1;
          ap_prot_d     = 4'b0010;
          ap_wdata_d    = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ap_valid_q     <= 1'b0;
      ap_ch_q        <= CH_IF;
      ap_write_q     <= 1'b0;
      ap_size_q      <= '0;
      ap_unsigned_q  <= 1'b0;
      ap_prot_q      <= '0;
      ap_addr_q      <= '0;
      ap_wdata_q     <= '0;
      dp_valid_q     <= 1'b0;
      dp_ch_q        <= CH_IF;
      dp_write_q     <= 1'b0;
      dp_size_q      <= '0;
      dp_unsigned_q  <= 1'b0;
      dp_off_q       <= '0;
      dp_wdata_q     <= '0;
      rr_last_q      <= CH_IF;
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      if_rsp_rdata_q <= '0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_err_q   <= 1'b0;
      ls_rsp_rdata_q <= '0;
    end else begin
      ap_valid_q     <= ap_valid_d;
      ap_ch_q        <= ap_ch_d;
      ap_write_q     <= ap_write_d;
      ap_size_q      <= ap_size_d;
      ap_unsigned_q  <= ap_unsigned_d;
      ap_prot_q      <= ap_prot_d;
      ap_addr_q      <= ap_addr_d;
      ap_wdata_q     <= ap_wdata_d;
      dp_valid_q     <= dp_valid_d;
      dp_ch_q        <= dp_ch_d;
      dp_write_q     <= dp_write_d;
      dp_size_q      <= dp_size_d;
      dp_unsigned_q  <= dp_unsigned_d;
      dp_off_q       <= dp_off_d;
      dp_wdata_q     <= dp_wdata_d;
      rr_last_q      <= rr_last_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_err_q   <= if_rsp_err_d;
      if_rsp_rdata_q <= if_rsp_rdata_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      ls_rsp_err_q   <= ls_rsp_err_d;
      ls_rsp_rdata_q <= ls_rsp_rdata_d;
    end
  end

  assign HADDR        = ap_addr_q;
  assign HSIZE        = {1'b0, ap_size_q};
  assign HTRANS       = (ap_valid_q && !HRESP) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE       = ap_write_q;
  assign HWDATA       = dp_wdata_q;
  assign HBURST       = 3'b000;
  assign HPROT        = ap_prot_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_err   = if_rsp_err_q;
  assign if_rsp_rdata = if_rsp_rdata_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign ls_rsp_err   = ls_rsp_err_q;
  assign ls_rsp_rdata = ls_rsp_rdata_q;

endmodule
